// File: rtl/tx_sched_pkg.sv
// Shared definitions for the transmit symbol scheduler: state encoding and default symbol values.
// The PRE state exists only when TX_PREAMBLE_EN is defined.
package tx_sched_pkg;

    localparam int          TX_SYMB_W        = 16;
    localparam logic [15:0] TX_IDLE_SYMB     = 16'h0000;
    localparam logic [15:0] TX_PREAMBLE_SYMB = 16'hA5A5;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_RUN   = 2'd1;
    localparam logic [1:0] ENC_FLUSH = 2'd2;
    localparam logic [1:0] ENC_PRE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_RUN   = ENC_RUN,
`ifdef TX_PREAMBLE_EN
        ST_PRE   = ENC_PRE,
`endif
        ST_FLUSH = ENC_FLUSH
    } state_t;

endpackage

// File: rtl/symb_fifo.sv
// Synchronous symbol FIFO with registered level/full/empty; head entry is read straight from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module symb_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] level_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    // NOTE: storage has no reset; an entry is only read after being written, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Buffers upstream symbols and issues them to the transmitter with a read strobe every SYMB_PERIOD clocks.
// Define TX_PREAMBLE_EN to send PREAMBLE_LEN preamble symbols at each start.
module tx_symbol_scheduler
    import tx_sched_pkg::*;
#(
    parameter int                SYMB_W        = TX_SYMB_W,
    parameter int                SYMB_PERIOD   = 3,
    parameter int                FIFO_DEPTH    = 4,
    parameter logic [SYMB_W-1:0] IDLE_SYMB     = SYMB_W'(TX_IDLE_SYMB)
`ifdef TX_PREAMBLE_EN
    ,
    parameter logic [SYMB_W-1:0] PREAMBLE_SYMB = SYMB_W'(TX_PREAMBLE_SYMB),
    parameter int                PREAMBLE_LEN  = 2
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [SYMB_W-1:0]             s_data,
    output logic                          s_ready,
    input  logic                          enable,
    output logic [SYMB_W-1:0]             symb_in,
    output logic                          read,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy
);

    localparam int PW = $clog2(SYMB_PERIOD);

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     phase;
    logic              tick;
    logic              run_slot;
    logic              strobe;
    logic              pop;
    logic              underrun_next;
    logic [SYMB_W-1:0] symb_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SYMB_W-1:0] fifo_dout;

`ifdef TX_PREAMBLE_EN
    localparam int PCW = $clog2(PREAMBLE_LEN + 1);
    logic [PCW-1:0] pre_cnt;
    logic [PCW-1:0] pre_cnt_next;
`endif

    symb_fifo #(
        .W     (SYMB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign s_ready = !fifo_full;
    assign busy    = (state != ST_IDLE);
    assign tick    = (state != ST_IDLE) && (phase == PW'(SYMB_PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        run_slot      = 1'b0;
        strobe        = 1'b0;
        pop           = 1'b0;
        underrun_next = 1'b0;
        symb_next     = symb_in;
`ifdef TX_PREAMBLE_EN
        pre_cnt_next  = pre_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (enable) begin
`ifdef TX_PREAMBLE_EN
                    strobe    = 1'b1;
                    symb_next = PREAMBLE_SYMB;
                    if (PREAMBLE_LEN == 1) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next   = ST_PRE;
                        pre_cnt_next = PCW'(1);
                    end
`else
                    run_slot   = 1'b1;
                    state_next = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                run_slot = tick;
                if (!enable) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Re-enabling mid-drain resumes RUN on the existing cadence.
                if (enable) begin
                    run_slot   = tick;
                    state_next = ST_RUN;
                end else if (tick && !fifo_empty) begin
                    strobe    = 1'b1;
                    pop       = 1'b1;
                    symb_next = fifo_dout;
                end else if (tick) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef TX_PREAMBLE_EN
            ST_PRE: begin
                if (tick) begin
                    strobe    = 1'b1;
                    symb_next = PREAMBLE_SYMB;
                    if (pre_cnt == PCW'(PREAMBLE_LEN - 1)) begin
                        pre_cnt_next = '0;
                        state_next   = enable ? ST_RUN : ST_FLUSH;
                    end else begin
                        pre_cnt_next = pre_cnt + PCW'(1);
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        // A RUN slot always strobes: queued data if any, otherwise the idle filler.
        if (run_slot) begin
            strobe = 1'b1;
            if (!fifo_empty) begin
                pop       = 1'b1;
                symb_next = fifo_dout;
            end else begin
                symb_next     = IDLE_SYMB;
                underrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= '0;
            read     <= 1'b0;
            underrun <= 1'b0;
            symb_in  <= '0;
        end else begin
            if (strobe || tick)           phase <= '0;
            else if (state != ST_IDLE)    phase <= phase + PW'(1);
            read     <= strobe;
            underrun <= underrun_next;
            symb_in  <= symb_next;
        end
    end

`ifdef TX_PREAMBLE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_cnt <= '0;
        else        pre_cnt <= pre_cnt_next;
    end
`endif

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed scoreboard bench for tx_symbol_scheduler: accepted pushes queue expected symbols, strobes pop them.
// Works with or without TX_PREAMBLE_EN (preamble strobes are expected at every start when it is defined).
module tb_tx_symbol_scheduler;

    localparam int          P      = 3;
    localparam logic [15:0] IDLE_V = 16'h0000;
    localparam logic [15:0] PRE_V  = 16'hA5A5;
`ifdef TX_PREAMBLE_EN
    localparam int PRE_LEN = 2;
`else
    localparam int PRE_LEN = 0;
`endif

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        enable;
    logic [15:0] symb_in;
    logic        read;
    logic        underrun;
    logic [2:0]  level;
    logic        busy;

    tx_symbol_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .enable   (enable),
        .symb_in  (symb_in),
        .read     (read),
        .underrun (underrun),
        .level    (level),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    logic [15:0] sb_q[$];
    int          pre_left       = 0;
    int          last_read      = -1;
    int          first_read_cyc = -1;
    int          first_pop_cyc  = -1;
    int          last_acc_cyc   = -1;
    int          n_reads        = 0;
    int          n_under        = 0;
    int          en_cyc;
    int          reads0;
    int          under0;
    logic [15:0] t2_syms [3] = '{16'h16A1, 16'hE95F, 16'h0000};
    logic [15:0] t4_syms [5] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note what the edge will accept/start, then score outputs at the next falling edge.
    task automatic step();
        logic        acc;
        logic [15:0] acc_d;
        logic        start;
        logic [15:0] exp_s;
        logic        exp_u;
        acc   = s_valid && s_ready && reset;
        acc_d = s_data;
        start = !busy && enable && reset;
        @(negedge clk);
        cyc++;
        if (start) pre_left = PRE_LEN;
        if (read) begin
            if (first_read_cyc < 0) first_read_cyc = cyc;
            if (pre_left > 0) begin
                exp_s = PRE_V;
                exp_u = 1'b0;
                pre_left--;
            end else if (sb_q.size() > 0) begin
                exp_s = sb_q.pop_front();
                exp_u = 1'b0;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end else begin
                exp_s = IDLE_V;
                exp_u = 1'b1;
            end
            check("symb_in", 32'(symb_in), 32'(exp_s));
            check("underrun", 32'(underrun), 32'(exp_u));
            if (last_read >= 0) check("read_gap", cyc - last_read, P);
            last_read = cyc;
            n_reads++;
            if (underrun) n_under++;
        end else if (underrun) begin
            check("underrun_without_read", 32'(underrun), 0);
        end
        if (acc) begin
            sb_q.push_back(acc_d);
            last_acc_cyc = cyc;
        end
    endtask

    task automatic new_test();
        last_read      = -1;
        first_read_cyc = -1;
        first_pop_cyc  = -1;
        reads0         = n_reads;
        under0         = n_under;
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check("reach_idle", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        enable  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_read", 32'(read), 0);
        check("rst_symb_in", 32'(symb_in), 0);
        check("rst_level", 32'(level), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        reset = 1'b1;
        step();

        // Three queued symbols, one-cycle enable: sent in order on the cadence, then drain to IDLE.
        new_test();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = t2_syms[i];
            step();
        end
        s_valid = 1'b0;
        check("t2_level_full", 32'(level), 3);
        enable = 1'b1;
        en_cyc = cyc;
        step();
        enable = 1'b0;
        check("t2_first_read_latency", first_read_cyc - en_cyc, 1);
        run_idle(40);
        check("t2_reads", n_reads - reads0, 3 + PRE_LEN);
        check("t2_underruns", n_under - under0, 0);
        check("t2_level_end", 32'(level), 0);

        // Enabled for 10 clocks with nothing queued: idle filler with underrun on each strobe.
        new_test();
        enable = 1'b1;
        repeat (10) step();
        enable = 1'b0;
        run_idle(20);
        check("t3_reads", n_reads - reads0, 4);
        check("t3_underruns", n_under - under0, 4 - PRE_LEN);

        // Five back-to-back pushes while disabled: fifth waits for the first pop.
        new_test();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = t4_syms[i];
            step();
        end
        s_data = t4_syms[4];
        step();
        check("t4_s_ready_full", 32'(s_ready), 0);
        check("t4_level_full", 32'(level), 4);
        enable = 1'b1;
        for (int i = 0; i < 20 && s_valid; i++) begin
            step();
            enable = 1'b0;
            if (last_acc_cyc == cyc) s_valid = 1'b0;
        end
        check("t4_fifth_accepted", 32'(s_valid), 0);
        check("t4_accept_after_pop", last_acc_cyc - first_pop_cyc, 1);
        run_idle(60);
        check("t4_reads", n_reads - reads0, 5 + PRE_LEN);
        check("t4_underruns", n_under - under0, 0);
        check("t4_level_end", 32'(level), 0);

`ifdef TX_PREAMBLE_EN
        // Preamble then one data symbol.
        new_test();
        s_valid = 1'b1;
        s_data  = 16'hE95F;
        step();
        s_valid = 1'b0;
        enable  = 1'b1;
        step();
        enable  = 1'b0;
        run_idle(30);
        check("t6_reads", n_reads - reads0, 3);
        check("t6_underruns", n_under - under0, 0);
`endif

        // Asynchronous reset mid-RUN with symbols still queued.
        new_test();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = t4_syms[i];
            step();
        end
        s_valid = 1'b0;
        enable  = 1'b1;
        step();
        check("t1_read_before_reset", 32'(read), 1);
        check("t1_level_before_reset", 32'(level), (PRE_LEN == 0) ? 3 : 4);
        #2 reset = 1'b0;
        #1;
        check("t1_read", 32'(read), 0);
        check("t1_symb_in", 32'(symb_in), 0);
        check("t1_level", 32'(level), 0);
        check("t1_s_ready", 32'(s_ready), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_underrun", 32'(underrun), 0);
        sb_q.delete();
        pre_left = 0;
        enable   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        check("t1_idle_after_release", 32'(busy), 0);
        check("t1_no_read_after_release", 32'(read), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
